sipo_deserializer: RTL and testbench

- Serial-In-Parallel-Out receiver. Sits directly downstream of the PISO serializer and consumes its serial bit stream plus per-bit valid.
- Reassembles DATA_WIDTH-bit words and presents them on a valid/ready parallel interface.
- Detects mid-word stalls (gap timeout) and output overrun.

---
 rtl/serial_link_pkg.sv | 31 +++
 rtl/sipo_out_buf.sv | 70 +++++++
 rtl/sipo_deserializer.sv | 195 +++++++++++++++++++
 tb/tb_sipo_deserializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
//   Definitions shared by the PISO serializer and the SIPO deserializer:
//   - SERIAL_DATA_WIDTH : default word width used on both ends of the link
//   - BIT_ORDER_*       : bit-order selector values for the MSB_FIRST parameter
//   - sipo_state_e      : receiver assembly state
//   - cnt_width()       : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package serial_link_pkg;

  localparam int SERIAL_DATA_WIDTH = 8;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sipo_state_e;

  // Bits needed to count 0..max_val; never narrower than one bit so that a
  // zero-valued limit still yields a legal vector width.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// ---------------------------------------------------------------------------
// sipo_out_buf
//   One-deep valid/ready holding register for assembled words.
//   A word offered while the register is empty, or while its current word is
//   being accepted, is loaded. A word offered while an unaccepted word is held
//   is dropped and reported with a one-cycle overrun pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   word_valid in   a completed word is offered this cycle
//   word_data  in   the completed word
//   ready_in   in   downstream accepts when valid_out && ready_in
//   data_out   out  held word
//   valid_out  out  data_out holds a word not yet accepted
//   overrun    out  one-cycle pulse: an offered word was dropped
// ---------------------------------------------------------------------------
module sipo_out_buf
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = SERIAL_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  overrun
);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  overrun_r;

  logic                  accept_s;
  logic                  load_s;
  logic                  drop_s;

  // Handshake decode: the register frees up in the same cycle it is accepted,
  // so a completing word may take its place without a bubble.
  assign accept_s = valid_r & ready_in;
  assign load_s   = word_valid & (~valid_r | ready_in);
  assign drop_s   = word_valid & valid_r & ~ready_in;

  // Holding register, valid flag and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= drop_s;
      if (load_s) begin
        data_r  <= word_data;
        valid_r <= 1'b1;
      end else if (accept_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
  assign overrun   = overrun_r;

endmodule

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in / parallel-out receiver. Samples one bit per valid_in cycle,
//   assembles DATA_WIDTH-bit words and hands them to a one-deep valid/ready
//   output register. A partial word that stalls for GAP_TIMEOUT consecutive
//   idle cycles is discarded with a one-cycle abort pulse.
//
// Parameters:
//   DATA_WIDTH  bits per word
//   MSB_FIRST   1: first received bit ends in data_out[DATA_WIDTH-1]
//               0: first received bit ends in data_out[0]
//   GAP_TIMEOUT idle cycles that abort a partial word (0 disables abort)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   data_in    in   serial bit
//   valid_in   in   data_in valid this cycle
//   data_out   out  assembled word
//   valid_out  out  data_out valid, held until accepted
//   ready_in   in   downstream accept
//   busy       out  partial word in progress
//   overrun    out  one-cycle pulse: completed word dropped
//   abort      out  one-cycle pulse: partial word discarded on gap timeout
// ---------------------------------------------------------------------------
module sipo_deserializer
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH  = SERIAL_DATA_WIDTH,
  parameter bit MSB_FIRST   = BIT_ORDER_MSB_FIRST,
  parameter int GAP_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  overrun,
  output logic                  abort
);

  localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);
  localparam int GAP_CNT_W = cnt_width(GAP_TIMEOUT);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  sipo_state_e           state_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  busy_r;
  logic                  abort_r;

  logic                  sample_bit_s;
  logic [DATA_WIDTH-1:0] shift_nxt_s;
  logic                  word_done_s;
  logic                  gap_hit_s;

  // Gate the serial bit so an undriven data_in during idle cycles can never
  // reach the shift register.
  assign sample_bit_s = valid_in & data_in;

  // Shift register with the new bit inserted at the end opposite to where the
  // first bit must finally rest.
  always_comb begin
    shift_nxt_s = shift_r;
    if (MSB_FIRST) begin
      shift_nxt_s    = shift_r << 1;
      shift_nxt_s[0] = sample_bit_s;
    end else begin
      shift_nxt_s                 = shift_r >> 1;
      shift_nxt_s[DATA_WIDTH-1]   = sample_bit_s;
    end
  end

  // The bit sampled when the count sits at DATA_WIDTH-1 completes the word.
  // With DATA_WIDTH=1 this already holds in IDLE (count 0).
  assign word_done_s = valid_in & (bit_cnt_r == LAST_BIT);

  generate
    if (GAP_TIMEOUT > 0) begin : g_gap
      localparam logic [GAP_CNT_W-1:0] GAP_LIMIT = GAP_CNT_W'(GAP_TIMEOUT);

      logic [GAP_CNT_W-1:0] gap_cnt_r;
      logic [GAP_CNT_W-1:0] gap_inc_s;

      // Saturating increment of the idle-cycle count.
      always_comb begin
        gap_inc_s = gap_cnt_r;
        if (gap_cnt_r != GAP_LIMIT) begin
          gap_inc_s = gap_cnt_r + 1'b1;
        end else begin
          gap_inc_s = gap_cnt_r;
        end
      end

      // Timeout fires on the idle cycle that brings the count up to the limit.
      assign gap_hit_s = (state_r == ST_SHIFT) & ~valid_in & (gap_inc_s == GAP_LIMIT);

      // Idle-cycle counter: only runs mid-word, cleared by any sampled bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          gap_cnt_r <= '0;
        end else if ((state_r != ST_SHIFT) || valid_in || gap_hit_s) begin
          gap_cnt_r <= '0;
        end else begin
          gap_cnt_r <= gap_inc_s;
        end
      end
    end else begin : g_no_gap
      assign gap_hit_s = 1'b0;
    end
  endgenerate

  // Assembly FSM: bit counter, shift register, busy flag and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      busy_r    <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_in) begin
            shift_r <= shift_nxt_s;
            if (word_done_s) begin
              bit_cnt_r <= '0;
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              bit_cnt_r <= BIT_CNT_W'(1);
              busy_r    <= 1'b1;
              state_r   <= ST_SHIFT;
            end
          end else begin
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (valid_in) begin
            shift_r <= shift_nxt_s;
            if (word_done_s) begin
              bit_cnt_r <= '0;
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
              busy_r    <= 1'b1;
              state_r   <= ST_SHIFT;
            end
          end else if (gap_hit_s) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            abort_r   <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          shift_r   <= '0;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Completed words are offered in the same cycle as their last bit, so the
  // registered output appears one cycle after that bit was sampled.
  sipo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .word_valid (word_done_s),
    .word_data  (shift_nxt_s),
    .ready_in   (ready_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .overrun    (overrun)
  );

  assign busy  = busy_r;
  assign abort = abort_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deserializer
//   Directed bench. Stimulus pushes the words it expects to be delivered into
//   a queue; a monitor pops and compares on every valid_out && ready_in
//   handshake. A second instance with MSB_FIRST=0 shares the serial inputs.
// ---------------------------------------------------------------------------
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       busy;
  logic       overrun;
  logic       abort;

  logic [7:0] lsb_data_out;
  logic       lsb_valid_out;
  logic       lsb_busy;
  logic       lsb_overrun;
  logic       lsb_abort;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         last_acc  = 0;
  int         prev_acc  = 0;
  int         ovr_cnt   = 0;
  int         abort_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_deserializer #(
    .DATA_WIDTH  (8),
    .MSB_FIRST   (1'b1),
    .GAP_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .busy      (busy),
    .overrun   (overrun),
    .abort     (abort)
  );

  sipo_deserializer #(
    .DATA_WIDTH  (8),
    .MSB_FIRST   (1'b0),
    .GAP_TIMEOUT (4)
  ) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (lsb_data_out),
    .valid_out (lsb_valid_out),
    .ready_in  (1'b1),
    .busy      (lsb_busy),
    .overrun   (lsb_overrun),
    .abort     (lsb_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter for handshake spacing.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compare every accepted word against the scoreboard, count pulses.
  initial begin
    logic [7:0] exp_w;
    forever begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
      if (abort) abort_cnt++;
      if (!rst && valid_out && ready_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected: got 0x%0h, required no word", data_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (data_out !== exp_w) begin
            n_fail++;
            $display("FAIL word_data: got 0x%0h, required 0x%0h", data_out, exp_w);
          end
        end
        prev_acc = last_acc;
        last_acc = cyc;
      end
    end
  end

  task automatic drive_bit(input logic b);
    valid_in = 1'b1;
    data_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    data_in  = 1'bx;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i]);
    end
  endtask

  initial begin
    logic [7:0] w;
    int         ovr0;
    int         ab0;

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data_out, 8'h00);
    check("reset_valid", valid_out, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_abort", abort, 1'b0);
    rst = 1'b0;
    idle(1);

    // 1: single word, latency and busy window
    exp_q.push_back(8'h10);
    w = 8'h10;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i > 0) begin
        check("t1_busy_mid", busy, 1'b1);
        check("t1_valid_early", valid_out, 1'b0);
      end
    end
    check("t1_valid", valid_out, 1'b1);
    check("t1_data", data_out, 8'h10);
    check("t1_busy_done", busy, 1'b0);
    idle(1);
    check("t1_valid_one_cycle", valid_out, 1'b0);
    idle(2);

    // 2: back-to-back words, no gap
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h07);
    send_word(8'h80);
    send_word(8'h07);
    idle(2);
    check("t2_spacing", last_acc - prev_acc, 8);
    check("t2_no_overrun", ovr_cnt - ovr0, 0);
    check("t2_drained", exp_q.size(), 0);

    // 3: backpressure, second word dropped
    ready_in = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h19);
    send_word(8'h19);
    send_word(8'hA5);
    check("t3_overrun_pulse", overrun, 1'b1);
    check("t3_held_data", data_out, 8'h19);
    check("t3_held_valid", valid_out, 1'b1);
    idle(1);
    check("t3_overrun_end", overrun, 1'b0);
    check("t3_overrun_count", ovr_cnt - ovr0, 1);
    ready_in = 1'b1;
    idle(1);
    check("t3_valid_drop", valid_out, 1'b0);
    idle(3);
    check("t3_no_a5", valid_out, 1'b0);
    check("t3_drained", exp_q.size(), 0);

    // 4: tolerated gap, then aborting gap, then recovery
    exp_q.push_back(8'h3C);
    w = 8'h3C;
    for (int i = 7; i >= 4; i--) drive_bit(w[i]);
    idle(3);
    check("t4_busy_in_gap", busy, 1'b1);
    for (int i = 3; i >= 0; i--) drive_bit(w[i]);
    idle(2);
    check("t4_gap3_delivered", exp_q.size(), 0);
    ab0 = abort_cnt;
    w = 8'hFF;
    for (int i = 7; i >= 4; i--) drive_bit(w[i]);
    idle(3);
    check("t4_no_abort_yet", abort, 1'b0);
    idle(1);
    check("t4_abort_pulse", abort, 1'b1);
    check("t4_abort_busy", busy, 1'b0);
    idle(1);
    check("t4_abort_end", abort, 1'b0);
    check("t4_abort_count", abort_cnt - ab0, 1);
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    idle(2);
    check("t4_recover", exp_q.size(), 0);

    // 5: reset mid-word and with a held word
    ab0 = abort_cnt;
    w = 8'hE7;
    for (int i = 7; i >= 3; i--) drive_bit(w[i]);
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_valid", valid_out, 1'b0);
    check("t5_rst_data", data_out, 8'h00);
    check("t5_rst_abort", abort, 1'b0);
    rst      = 1'b0;
    ready_in = 1'b0;
    send_word(8'h6E);
    idle(1);
    check("t5_held", valid_out, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst2_valid", valid_out, 1'b0);
    check("t5_rst2_data", data_out, 8'h00);
    check("t5_rst2_overrun", overrun, 1'b0);
    rst      = 1'b0;
    ready_in = 1'b1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3);
    check("t5_c3_valid", valid_out, 1'b1);
    check("t5_c3_data", data_out, 8'hC3);
    idle(2);
    check("t5_no_abort", abort_cnt - ab0, 0);
    check("t5_drained", exp_q.size(), 0);

    // 6: LSB-first instance on the shared stream
    exp_q.push_back(8'h80);
    send_word(8'h80);
    check("t6_lsb_valid", lsb_valid_out, 1'b1);
    check("t6_lsb_data_01", lsb_data_out, 8'h01);
    exp_q.push_back(8'hA0);
    send_word(8'hA0);
    check("t6_lsb_data_05", lsb_data_out, 8'h05);
    idle(3);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
